// File: rtl/regfile_wb_if.sv
// regfile_wb_if: writeback request/port bundle between the two producers and the register-file write arbiter
interface regfile_wb_if;
    logic        s0_valid;
    logic        s0_ready;
    logic [4:0]  s0_wn;
    logic [31:0] s0_d;
    logic        s1_valid;
    logic        s1_ready;
    logic [4:0]  s1_wn;
    logic [31:0] s1_d;
    logic        we;
    logic [4:0]  wn;
    logic [31:0] d;
    logic        busy;
    modport master (
        output s0_valid, s0_wn, s0_d, s1_valid, s1_wn, s1_d,
        input  s0_ready, s1_ready, we, wn, d, busy
    );
    modport slave (
        input  s0_valid, s0_wn, s0_d, s1_valid, s1_wn, s1_d,
        output s0_ready, s1_ready, we, wn, d, busy
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: two per-source FIFOs drained one entry per cycle onto the register-file write port; WB_RR_EN selects round-robin, otherwise fixed priority to source 0
module regfile_wb_arbiter #(
    parameter int DEPTH = 2
) (
    input logic         clk,
    input logic         clr,
    regfile_wb_if.slave bus
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    typedef logic [PW-1:0] ptr_t;
    typedef logic [36:0] ent_t;
    ent_t       mem_q [2][DEPTH];
    ptr_t       wp_q [2];
    ptr_t       wp_d [2];
    ptr_t       rp_q [2];
    ptr_t       rp_d [2];
    logic [3:0] cnt_q [2];
    logic [3:0] cnt_d [2];
    ent_t       din [2];
    ent_t       head;
    logic [1:0] valid, ready, push, ne, grant;

    function automatic ptr_t inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign valid  = {bus.s1_valid, bus.s0_valid};
    assign din[0] = {bus.s0_wn, bus.s0_d};
    assign din[1] = {bus.s1_wn, bus.s1_d};
    assign ne     = {cnt_q[1] != 4'd0, cnt_q[0] != 4'd0};

`ifdef WB_RR_EN
    logic last_q, last_d;
    // Last-grant pointer; reset to 1 so source 0 wins the first contention
    always_ff @(posedge clk) begin
        last_q <= clr ? 1'b1 : last_d;
    end
`endif

    // Grant: a lone non-empty FIFO wins; contention resolved by round-robin or fixed priority
    always_comb begin
`ifdef WB_RR_EN
        grant[1] = ne[1] && (!ne[0] || !last_q);
        last_d   = (|grant) ? grant[1] : last_q;
`else
        grant[1] = ne[1] && !ne[0];
`endif
        grant[0] = ne[0] && !grant[1];
    end

    // Ready from registered count only (no pass-through when full); next pointers and counts
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            ready[i] = !clr && (cnt_q[i] < 4'(DEPTH));
            push[i]  = valid[i] && ready[i];
            wp_d[i]  = push[i] ? inc(wp_q[i]) : wp_q[i];
            rp_d[i]  = grant[i] ? inc(rp_q[i]) : rp_q[i];
            cnt_d[i] = cnt_q[i] + 4'(push[i]) - 4'(grant[i]);
        end
    end

    // Pointer and count registers; clr discards every pending entry
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            wp_q[i]  <= clr ? '0 : wp_d[i];
            rp_q[i]  <= clr ? '0 : rp_d[i];
            cnt_q[i] <= clr ? '0 : cnt_d[i];
        end
    end

    // Entry storage, written only on accepted pushes
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) mem_q[i][wp_q[i]] <= din[i];
        end
    end

    assign head         = grant[1] ? mem_q[1][rp_q[1]] : grant[0] ? mem_q[0][rp_q[0]] : '0;
    assign bus.wn       = head[36:32];
    assign bus.d        = head[31:0];
    assign bus.we       = head[36:32] != 5'd0;
    assign bus.busy     = |ne;
    assign bus.s0_ready = ready[0];
    assign bus.s1_ready = ready[1];
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: table vectors, ordering sequences, clr flush, DEPTH=1 throughput and random traffic against a queue model
module tb_regfile_wb_arbiter;
    localparam int DEPTH = 2;
`ifdef WB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic clr1 = 1'b1;
    always #5 clk = ~clk;

    regfile_wb_if bus();
    regfile_wb_if bus1();
    regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (.clk(clk), .clr(clr), .bus(bus));
    regfile_wb_arbiter #(.DEPTH(1)) dut1 (.clk(clk), .clr(clr1), .bus(bus1));

    typedef struct packed {logic [4:0] wn; logic [31:0] d;} ent_t;
    typedef struct {
        logic v0; logic [4:0] w0; logic [31:0] d0;
        logic v1; logic [4:0] w1; logic [31:0] d1;
        logic c;
        logic we; logic [4:0] wn; logic [31:0] d; logic busy; logic r0; logic r1;
    } vec_t;

    int total = 0;
    int bad = 0;
    ent_t q0[$];
    ent_t q1[$];
    bit last = 1'b1;
    logic [4:0] seen[$];
    logic s_we, s_busy, s_r0, s_r1;
    logic [4:0] s_wn;
    logic [31:0] s_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive, compare against the queue model, then advance the model at the edge
    task automatic cycle(input logic v0, input logic [4:0] w0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] w1, input logic [31:0] d1,
                         input logic c, output logic a0, output logic a1);
        ent_t h;
        logic g0, g1, er0, er1;
        @(negedge clk);
        bus.s0_valid = v0; bus.s0_wn = w0; bus.s0_d = d0;
        bus.s1_valid = v1; bus.s1_wn = w1; bus.s1_d = d1;
        clr = c;
        #1;
        g1 = q1.size() > 0 && (q0.size() == 0 || (RR && !last));
        g0 = q0.size() > 0 && !g1;
        h = g1 ? q1[0] : g0 ? q0[0] : '0;
        er0 = !c && q0.size() < DEPTH;
        er1 = !c && q1.size() < DEPTH;
        s_we = bus.we; s_wn = bus.wn; s_d = bus.d; s_busy = bus.busy; s_r0 = bus.s0_ready; s_r1 = bus.s1_ready;
        chk("we", 32'(s_we), 32'((g0 || g1) && h.wn != 5'd0));
        chk("wn", 32'(s_wn), 32'(h.wn));
        chk("d", s_d, h.d);
        chk("busy", 32'(s_busy), 32'(q0.size() + q1.size() > 0));
        chk("s0_ready", 32'(s_r0), 32'(er0));
        chk("s1_ready", 32'(s_r1), 32'(er1));
        if (s_we) seen.push_back(s_wn);
        a0 = v0 && er0;
        a1 = v1 && er1;
        @(posedge clk);
        if (c) begin
            q0.delete(); q1.delete(); last = 1'b1;
        end else begin
            if (g0) void'(q0.pop_front());
            if (g1) void'(q1.pop_front());
            if (g0 || g1) last = g1;
            if (a0) q0.push_back({w0, d0});
            if (a1) q1.push_back({w1, d1});
        end
    endtask

    initial begin
        vec_t tbl[8];
        logic a0, a1, prev, p, r1_dropped;
        logic [4:0] exp_seq[8];
        int i0, i1, n;
        bus.s0_valid = 0; bus.s0_wn = 0; bus.s0_d = 0;
        bus.s1_valid = 0; bus.s1_wn = 0; bus.s1_d = 0;
        bus1.s0_valid = 0; bus1.s0_wn = 0; bus1.s0_d = 0;
        bus1.s1_valid = 0; bus1.s1_wn = 0; bus1.s1_d = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr1 = 1'b0;
        prev = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus1.s0_valid = 1'b1; bus1.s0_wn = 5'd9; bus1.s0_d = 32'(i);
            #1;
            p = bus1.s0_valid && bus1.s0_ready;
            chk("d1_ready", 32'(bus1.s0_ready), 32'(i % 2 == 0));
            chk("d1_we", 32'(bus1.we), 32'(i % 2 == 1));
            chk("d1_consec_push", 32'(p && prev), 32'd0);
            prev = p;
        end
        @(negedge clk);
        bus1.s0_valid = 1'b0;

        tbl[0] = '{1, 5, 32'h1234, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0};
        tbl[1] = '{1, 5, 32'h1234, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1};
        tbl[2] = '{0, 0, 0, 0, 0, 0, 0,         1, 5, 32'h1234, 1, 1, 1};
        tbl[3] = '{0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 1, 1};
        tbl[4] = '{0, 0, 0, 1, 0, 32'hFFFF, 0,  0, 0, 0, 0, 1, 1};
        tbl[5] = '{0, 0, 0, 1, 7, 32'hA, 0,     0, 0, 32'hFFFF, 1, 1, 1};
        tbl[6] = '{0, 0, 0, 0, 0, 0, 0,         1, 7, 32'hA, 1, 1, 1};
        tbl[7] = '{0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 1, 1};
        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].v0, tbl[i].w0, tbl[i].d0, tbl[i].v1, tbl[i].w1, tbl[i].d1, tbl[i].c, a0, a1);
            chk($sformatf("tbl%0d_we", i), 32'(s_we), 32'(tbl[i].we));
            chk($sformatf("tbl%0d_wn", i), 32'(s_wn), 32'(tbl[i].wn));
            chk($sformatf("tbl%0d_d", i), s_d, tbl[i].d);
            chk($sformatf("tbl%0d_busy", i), 32'(s_busy), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d_r0", i), 32'(s_r0), 32'(tbl[i].r0));
            chk($sformatf("tbl%0d_r1", i), 32'(s_r1), 32'(tbl[i].r1));
        end

        if (RR) exp_seq = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13, 5'd4, 5'd14};
        else    exp_seq = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd11, 5'd12, 5'd13, 5'd14};
        seen.delete();
        i0 = 0; i1 = 0; r1_dropped = 1'b0;
        for (int k = 0; k < 30; k++) begin
            cycle(i0 < 4, 5'(i0 + 1), 32'(100 + i0), i1 < 4, 5'(i1 + 11), 32'(200 + i1), 1'b0, a0, a1);
            if (i1 < 4 && !s_r1) r1_dropped = 1'b1;
            i0 += int'(a0);
            i1 += int'(a1);
        end
        chk("seq_len", 32'(seen.size()), 32'd8);
        for (int k = 0; k < 8; k++)
            chk($sformatf("seq%0d", k), 32'(k < seen.size() ? seen[k] : 5'd0), 32'(exp_seq[k]));
        chk("s1_ready_dropped", 32'(r1_dropped), 32'd1);

        for (int k = 0; k < 3; k++) cycle(1, 5'(20 + k), 32'(k), 1, 5'(24 + k), 32'(k), 1'b0, a0, a1);
        cycle(0, 0, 0, 0, 0, 0, 1'b1, a0, a1);
        n = seen.size();
        for (int k = 0; k < 4; k++) cycle(0, 0, 0, 0, 0, 0, 1'b0, a0, a1);
        chk("no_we_after_clr", 32'(seen.size() - n), 32'd0);
        chk("busy_after_clr", 32'(s_busy), 32'd0);
        chk("r0_after_clr", 32'(s_r0), 32'd1);
        chk("r1_after_clr", 32'(s_r1), 32'd1);

        for (int k = 0; k < 400; k++)
            cycle(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                  $urandom_range(0, 39) == 0, a0, a1);
        for (int k = 0; k < 6; k++) cycle(0, 0, 0, 0, 0, 0, 1'b0, a0, a1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
